// File: rtl/lsl33_pkg.sv
// lsl33_pkg: shared constants and state encoding for the multi-cycle
// 33-bit logical-shift-left sequencer.
//   WIDTH    - datapath width (fixed at 33)
//   SHAMT_W  - width of the requested shift amount
//   STEP_MAX - largest shift the single stage performs per clock
package lsl33_pkg;

   localparam int WIDTH    = 33;
   localparam int SHAMT_W  = 6;
   localparam int STEP_MAX = 3;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

endpackage

// File: rtl/shl_step33.sv
// shl_step33: combinational 33-bit shift left by 0..3 with zero fill.
//   d_in  [32:0] - operand
//   step  [1:0]  - shift amount 0..3
//   d_out [32:0] - d_in << step
//   c_out        - last bit pushed out of bit 32 (d_in[33-step]), 0 when step=0
module shl_step33
   import lsl33_pkg::*;
(
   input  logic [WIDTH-1:0] d_in,
   input  logic [1:0]       step,
   output logic [WIDTH-1:0] d_out,
   output logic             c_out
);

   // Three zeros below bit 0 give every output bit a legal 4:1 mux source,
   // so ext[i+3] is d_in[i] and ext[i+3-k] is d_in[i-k] (or fill).
   logic [WIDTH+2:0] ext;
   assign ext = {d_in, 3'b000};

   for (genvar i = 0; i < WIDTH; i++) begin : g_mux
      assign d_out[i] = step[1] ? (step[0] ? ext[i]   : ext[i+1])
                                : (step[0] ? ext[i+2] : ext[i+3]);
   end

   always_comb begin
      c_out = 1'b0;
      case (step)
         2'd1:    c_out = d_in[WIDTH-1];
         2'd2:    c_out = d_in[WIDTH-2];
         2'd3:    c_out = d_in[WIDTH-3];
         default: c_out = 1'b0;
      endcase
   end

endmodule

// File: rtl/lsl33_seq.sv
// lsl33_seq: multi-cycle 33-bit logical shift left by 0..63, iterating a
// single shift-by-0..3 stage once per clock. One request at a time.
//   clk    - rising-edge clock
//   reset  - synchronous active-high reset
//   start  - request strobe, honoured only in IDLE or DONE
//   clear  - synchronous abort back to IDLE (also suppresses done)
//   d_in   - operand, captured on an accepted start
//   shamt  - total shift amount, captured on an accepted start
//   busy   - high while shifting
//   done   - one-cycle result-valid pulse
//   d_out  - result, held until the next accepted start or clear
//   c_out  - last bit shifted out of bit 32 (0 for shamt=0)
module lsl33_seq
   import lsl33_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   input  logic               clear,
   input  logic [WIDTH-1:0]   d_in,
   input  logic [SHAMT_W-1:0] shamt,
   output logic               busy,
   output logic               done,
   output logic [WIDTH-1:0]   d_out,
   output logic               c_out
);

   state_t             state, state_n;
   logic [WIDTH-1:0]   acc;
   logic [SHAMT_W-1:0] rem;
   logic               cbit;

   logic [1:0]         step;
   logic [WIDTH-1:0]   acc_sh;
   logic               step_cout;
   logic               load, shift_en;

   // Take the full stage width while it fits; the final step is the
   // remainder, so rem never goes below zero.
   assign step = (rem >= SHAMT_W'(STEP_MAX)) ? 2'd3 : rem[1:0];

   shl_step33 u_step (
      .d_in  (acc),
      .step  (step),
      .d_out (acc_sh),
      .c_out (step_cout)
   );

   always_comb begin
      state_n  = state;
      load     = 1'b0;
      shift_en = 1'b0;
      case (state)
         ST_IDLE, ST_DONE: begin
            if (start) begin
               load    = 1'b1;
               state_n = (shamt != '0) ? ST_SHIFT : ST_DONE;
            end else begin
               state_n = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            shift_en = 1'b1;
            if (rem == {{(SHAMT_W-2){1'b0}}, step}) state_n = ST_DONE;
         end
         default: state_n = ST_IDLE;
      endcase
      if (clear) begin
         state_n  = ST_IDLE;
         load     = 1'b0;
         shift_en = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= ST_IDLE;
         acc   <= '0;
         rem   <= '0;
         cbit  <= 1'b0;
      end else if (clear) begin
         state <= ST_IDLE;
         acc   <= '0;
         rem   <= '0;
         cbit  <= 1'b0;
      end else begin
         state <= state_n;
         if (load) begin
            acc  <= d_in;
            rem  <= shamt;
            cbit <= 1'b0;
         end else if (shift_en) begin
            acc  <= acc_sh;
            rem  <= rem - {{(SHAMT_W-2){1'b0}}, step};
            cbit <= step_cout;
         end
      end
   end

   assign busy  = (state == ST_SHIFT);
   // An abort on the DONE cycle withdraws the result pulse.
   assign done  = (state == ST_DONE) && !clear;
   assign d_out = acc;
   assign c_out = cbit;

endmodule

// File: tb/tb_lsl33_seq.sv
module tb_lsl33_seq;

   logic        clk = 1'b0;
   logic        reset, start, clear;
   logic [32:0] d_in;
   logic [5:0]  shamt;
   logic        busy, done, c_out;
   logic [32:0] d_out;

   int n_cmp = 0;
   int n_bad = 0;

   typedef struct {
      logic [32:0] d;
      logic [5:0]  s;
      logic [32:0] ed;
      logic        ec;
   } vec_t;

   typedef struct {
      logic [32:0] ed;
      logic        ec;
      int          lat;
      int          nbusy;
   } exp_t;

   exp_t sb[$];
   vec_t tv[8];

   lsl33_seq dut (
      .clk   (clk),
      .reset (reset),
      .start (start),
      .clear (clear),
      .d_in  (d_in),
      .shamt (shamt),
      .busy  (busy),
      .done  (done),
      .d_out (d_out),
      .c_out (c_out)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   // Independent reference: wide shift, then pick the bit that crossed bit 32.
   function automatic exp_t model(input logic [32:0] d, input logic [5:0] s);
      logic [127:0] full;
      exp_t e;
      full    = {95'b0, d} << s;
      e.ed    = full[32:0];
      e.ec    = (s == 0) ? 1'b0 : full[33];
      e.nbusy = (int'(s) + 2) / 3;
      e.lat   = e.nbusy + 1;
      return e;
   endfunction

   // Wait for done after an accepted start; optionally pulse start with junk
   // on cycle poke (0 = none). Returns at the negedge of the done cycle.
   task automatic wait_done(input string nm, input int poke);
      int   cyc, nb;
      bit   got;
      exp_t e;
      cyc = 0; nb = 0; got = 0;
      while (cyc < 40 && !got) begin
         @(negedge clk);
         cyc++;
         if (busy) nb++;
         if (done) begin
            got = 1;
            if (sb.size() == 0) begin
               chk({nm, " unexpected_done"}, 64'(cyc), 64'(0));
            end else begin
               e = sb.pop_front();
               chk({nm, " latency"}, 64'(cyc), 64'(e.lat));
               chk({nm, " busy_cycles"}, 64'(nb), 64'(e.nbusy));
               chk({nm, " d_out"}, 64'(d_out), 64'(e.ed));
               chk({nm, " c_out"}, 64'(c_out), 64'(e.ec));
            end
         end
         if (poke != 0 && cyc == poke) begin
            start = 1'b1; d_in = 33'h1_5A5A_5A5A; shamt = 6'd2;
         end else begin
            start = 1'b0;
         end
      end
      if (!got) begin
         chk({nm, " timeout"}, 64'(cyc), 64'(0));
         if (sb.size() != 0) void'(sb.pop_front());
      end
   endtask

   // Caller is at a negedge; the next posedge accepts the request.
   task automatic run_op(input string nm, input logic [32:0] d, input logic [5:0] s,
                         input logic [32:0] ed, input logic ec, input int poke);
      exp_t e;
      e    = model(d, s);
      e.ed = ed;
      e.ec = ec;
      sb.push_back(e);
      d_in = d; shamt = s; start = 1'b1;
      wait_done(nm, poke);
   endtask

   task automatic idle_no_done(input string nm, input int n);
      int seen;
      seen = 0;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         if (done || busy) seen++;
      end
      chk({nm, " quiet"}, 64'(seen), 64'(0));
   endtask

   // Start a shamt=9 request, abort on the second SHIFT cycle with clear or reset.
   task automatic abort_case(input string nm, input bit use_reset);
      d_in = 33'h1_2345_6789; shamt = 6'd9; start = 1'b1;
      @(negedge clk); start = 1'b0;            // cycle 1 (SHIFT)
      @(negedge clk);                          // cycle 2 (SHIFT)
      chk({nm, " busy_before"}, 64'(busy), 64'(1));
      if (use_reset) reset = 1'b1; else clear = 1'b1;
      @(negedge clk);
      reset = 1'b0; clear = 1'b0;
      chk({nm, " busy"}, 64'(busy), 64'(0));
      chk({nm, " done"}, 64'(done), 64'(0));
      chk({nm, " d_out"}, 64'(d_out), 64'(0));
      chk({nm, " c_out"}, 64'(c_out), 64'(0));
      idle_no_done(nm, 6);
   endtask

   initial begin
      exp_t e;
      logic [32:0] rd;
      logic [5:0]  rs;

      tv[0] = '{33'h0_0000_0001, 6'd0,  33'h0_0000_0001, 1'b0};
      tv[1] = '{33'h0_0000_0001, 6'd5,  33'h0_0000_0020, 1'b0};
      tv[2] = '{33'h1_0000_0000, 6'd1,  33'h0_0000_0000, 1'b1};
      tv[3] = '{33'h1_FFFF_FFFF, 6'd63, 33'h0_0000_0000, 1'b0};
      tv[4] = '{33'h0_0000_0001, 6'd33, 33'h0_0000_0000, 1'b1};
      tv[5] = '{33'h1_FFFF_FFFF, 6'd34, 33'h0_0000_0000, 1'b0};
      tv[6] = '{33'h1_2345_6789, 6'd4,  33'h0_3456_7890, 1'b1};
      tv[7] = '{33'h0_8000_0001, 6'd2,  33'h0_0000_0004, 1'b1};

      reset = 1'b1; start = 1'b0; clear = 1'b0; d_in = '0; shamt = '0;
      repeat (3) @(negedge clk);
      chk("reset busy", 64'(busy), 64'(0));
      chk("reset done", 64'(done), 64'(0));
      chk("reset d_out", 64'(d_out), 64'(0));
      chk("reset c_out", 64'(c_out), 64'(0));
      reset = 1'b0;
      @(negedge clk);

      for (int i = 0; i < 8; i++) begin
         run_op($sformatf("vec%0d", i), tv[i].d, tv[i].s, tv[i].ed, tv[i].ec, 0);
         @(negedge clk);
         chk($sformatf("vec%0d hold", i), 64'(d_out), 64'(tv[i].ed));
      end

      for (int i = 0; i < 8; i++) begin
         rd = {$urandom_range(1, 0), $urandom()};
         rs = 6'($urandom_range(63, 0));
         e  = model(rd, rs);
         run_op($sformatf("rnd%0d", i), rd, rs, e.ed, e.ec, 0);
         @(negedge clk);
      end

      // Back-to-back: second start rides on the first done cycle.
      run_op("b2b first", 33'h0_0000_0003, 6'd7, 33'h0_0000_0180, 1'b0, 0);
      run_op("b2b second", 33'h1_0000_0001, 6'd3, 33'h0_0000_0008, 1'b0, 0);
      idle_no_done("b2b tail", 3);

      abort_case("clear_abort", 1'b0);
      abort_case("reset_abort", 1'b1);

      // start pulsed mid-SHIFT is ignored; original result stands.
      run_op("start_ignored", 33'h0_0000_0005, 6'd9, 33'h0_0000_0A00, 1'b0, 2);
      idle_no_done("start_ignored", 6);
      chk("start_ignored hold", 64'(d_out), 64'(33'h0_0000_0A00));

      // clear on the DONE cycle withdraws the pulse and zeroes the result.
      d_in = 33'h0_0000_00FF; shamt = 6'd0; start = 1'b1;
      @(posedge clk); #1 start = 1'b0; clear = 1'b1;
      @(negedge clk);
      chk("clear_on_done done", 64'(done), 64'(0));
      @(posedge clk); #1 clear = 1'b0;
      @(negedge clk);
      chk("clear_on_done d_out", 64'(d_out), 64'(0));
      chk("clear_on_done done2", 64'(done), 64'(0));

      chk("scoreboard empty", 64'(sb.size()), 64'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
